pc_control_unit: RTL

//   Parametrised program-counter unit: holds the PC register and selects the next PC

---
 rtl/pc_control_unit.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/pc_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_control_unit
// Description : Program-counter unit for a multicycle MIPS core. Holds the PC
//               register and selects the next PC from NSRC packed sources.
//               Handles unconditional and conditional (beq/bne) writes,
//               stall, exception entry with EPC capture, misaligned-target
//               trapping and a one-cycle boot state after reset.
// Ports       : Clk, Reset_n        clock / async active-low reset
//               SrcData, PCSource   packed next-PC sources and select
//               PCWrite, PCWriteCond, CondInvert, Zero  write qualifiers
//               Stall, Exception    hold / exception request
//               PC, EPC             current PC, PC saved at last exception
//               Redirect            1-cycle pulse on non-sequential PC load
//               SelErr              sticky illegal-select flag
// Revision    : 1.0 - initial release
// ============================================================================
module pc_control_unit #(
  parameter int               WIDTH        = 32,
  parameter int               NSRC         = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h0000_0254),
  parameter bit               ALIGN_CHECK  = 1'b1
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic [NSRC*WIDTH-1:0]     SrcData,
  input  logic [$clog2(NSRC)-1:0]   PCSource,
  input  logic                      PCWrite,
  input  logic                      PCWriteCond,
  input  logic                      CondInvert,
  input  logic                      Zero,
  input  logic                      Stall,
  input  logic                      Exception,
  output logic [WIDTH-1:0]          PC,
  output logic [WIDTH-1:0]          EPC,
  output logic                      Redirect,
  output logic                      SelErr
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_EXC  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic             redirect_q, redirect_d;
  logic             sel_err_q, sel_err_d;

  logic             w_take;
  logic             w_sel_bad;
  logic             w_misaligned;
  logic [WIDTH-1:0] w_target;

  // PCWrite alone is enough to take; the branch path needs Zero (beq) or
  // !Zero (bne) depending on CondInvert.
  assign w_take    = PCWrite | (PCWriteCond & (Zero ^ CondInvert));

  // When NSRC is not a power of two the select field can encode sources
  // that do not exist; such selects must never load the PC.
  assign w_sel_bad = (int'(PCSource) >= NSRC);

  // Explicit compare-and-select mux so an out-of-range select yields zero
  // instead of an out-of-bounds part-select.
  always_comb begin
    w_target = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (int'(PCSource) == i) begin
        w_target = SrcData[i*WIDTH +: WIDTH];
      end
    end
  end

  assign w_misaligned = ALIGN_CHECK && (w_target[1:0] != 2'b00);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    epc_d      = epc_q;
    redirect_d = 1'b0;
    sel_err_d  = sel_err_q;

    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end

      ST_RUN: begin
        if (Exception) begin
          epc_d      = pc_q;
          pc_d       = EXC_VECTOR;
          redirect_d = 1'b1;
          state_d    = ST_EXC;
        end else if (Stall) begin
          // hold everything
        end else if (w_take) begin
          if (w_sel_bad) begin
            sel_err_d = 1'b1;
          end else if (w_misaligned) begin
            // A misaligned jump/branch target traps like an exception.
            epc_d      = pc_q;
            pc_d       = EXC_VECTOR;
            redirect_d = 1'b1;
            state_d    = ST_EXC;
          end else begin
            pc_d       = w_target;
            redirect_d = (PCSource != '0);
          end
        end
      end

      ST_EXC: begin
        // Exception handler entry cycle: no nesting, no writes.
        state_d = ST_RUN;
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_VECTOR;
      epc_q      <= '0;
      redirect_q <= 1'b0;
      sel_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      epc_q      <= epc_d;
      redirect_q <= redirect_d;
      sel_err_q  <= sel_err_d;
    end
  end

  assign PC       = pc_q;
  assign EPC      = epc_q;
  assign Redirect = redirect_q;
  assign SelErr   = sel_err_q;

endmodule
`default_nettype wire
